// File: rtl/axi_addr_filter_if.sv
// AXI4 bus bundle used by axi_addr_filter: full AW/W/B/AR/R channels with
// Master and Slave modports.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_addr_filter.sv
// AXI address filter: routes each transaction to mst_ok (window hit) or mst_err (miss).
// Define AXI_ADDR_FILTER_LOG_EN to add first-faulting-address capture (err_* ports).
module axi_addr_filter #(
  localparam int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1FC0_0000,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 32'hFFF0_0000
) (
  input  logic              aclk,
  input  logic              areset,
  AXI_BUS.Slave             slv,
  AXI_BUS.Master            mst_ok,
  AXI_BUS.Master            mst_err
`ifdef AXI_ADDR_FILTER_LOG_EN
  ,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              err_valid_o,
  input  logic              err_clr_i
`endif
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_BUSY} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic     wsel, rsel;          // 1 = mst_err
  logic     aw_hit, ar_hit;
  logic     aw_accept, ar_accept;
  logic     aw_dec_ready, ar_dec_ready;
  logic     w_sel_ready, b_sel_valid, r_sel_valid;

  assign aw_hit = (slv.aw_addr & ADDR_MASK) == BASE_ADDR;
  assign ar_hit = (slv.ar_addr & ADDR_MASK) == BASE_ADDR;

  assign aw_dec_ready = aw_hit ? mst_ok.aw_ready : mst_err.aw_ready;
  assign ar_dec_ready = ar_hit ? mst_ok.ar_ready : mst_err.ar_ready;
  assign w_sel_ready  = wsel ? mst_err.w_ready : mst_ok.w_ready;
  assign b_sel_valid  = wsel ? mst_err.b_valid : mst_ok.b_valid;
  assign r_sel_valid  = rsel ? mst_err.r_valid : mst_ok.r_valid;

  // Request payloads go to both masters; only the VALIDs steer the transaction.
  assign mst_ok.aw_id     = slv.aw_id;     assign mst_err.aw_id     = slv.aw_id;
  assign mst_ok.aw_addr   = slv.aw_addr;   assign mst_err.aw_addr   = slv.aw_addr;
  assign mst_ok.aw_len    = slv.aw_len;    assign mst_err.aw_len    = slv.aw_len;
  assign mst_ok.aw_size   = slv.aw_size;   assign mst_err.aw_size   = slv.aw_size;
  assign mst_ok.aw_burst  = slv.aw_burst;  assign mst_err.aw_burst  = slv.aw_burst;
  assign mst_ok.aw_lock   = slv.aw_lock;   assign mst_err.aw_lock   = slv.aw_lock;
  assign mst_ok.aw_cache  = slv.aw_cache;  assign mst_err.aw_cache  = slv.aw_cache;
  assign mst_ok.aw_prot   = slv.aw_prot;   assign mst_err.aw_prot   = slv.aw_prot;
  assign mst_ok.aw_qos    = slv.aw_qos;    assign mst_err.aw_qos    = slv.aw_qos;
  assign mst_ok.aw_region = slv.aw_region; assign mst_err.aw_region = slv.aw_region;
  assign mst_ok.aw_user   = slv.aw_user;   assign mst_err.aw_user   = slv.aw_user;

  assign mst_ok.w_data    = slv.w_data;    assign mst_err.w_data    = slv.w_data;
  assign mst_ok.w_strb    = slv.w_strb;    assign mst_err.w_strb    = slv.w_strb;
  assign mst_ok.w_last    = slv.w_last;    assign mst_err.w_last    = slv.w_last;
  assign mst_ok.w_user    = slv.w_user;    assign mst_err.w_user    = slv.w_user;

  assign mst_ok.ar_id     = slv.ar_id;     assign mst_err.ar_id     = slv.ar_id;
  assign mst_ok.ar_addr   = slv.ar_addr;   assign mst_err.ar_addr   = slv.ar_addr;
  assign mst_ok.ar_len    = slv.ar_len;    assign mst_err.ar_len    = slv.ar_len;
  assign mst_ok.ar_size   = slv.ar_size;   assign mst_err.ar_size   = slv.ar_size;
  assign mst_ok.ar_burst  = slv.ar_burst;  assign mst_err.ar_burst  = slv.ar_burst;
  assign mst_ok.ar_lock   = slv.ar_lock;   assign mst_err.ar_lock   = slv.ar_lock;
  assign mst_ok.ar_cache  = slv.ar_cache;  assign mst_err.ar_cache  = slv.ar_cache;
  assign mst_ok.ar_prot   = slv.ar_prot;   assign mst_err.ar_prot   = slv.ar_prot;
  assign mst_ok.ar_qos    = slv.ar_qos;    assign mst_err.ar_qos    = slv.ar_qos;
  assign mst_ok.ar_region = slv.ar_region; assign mst_err.ar_region = slv.ar_region;
  assign mst_ok.ar_user   = slv.ar_user;   assign mst_err.ar_user   = slv.ar_user;

  // Response payloads come from the port latched at address acceptance.
  assign slv.b_id   = wsel ? mst_err.b_id   : mst_ok.b_id;
  assign slv.b_resp = wsel ? mst_err.b_resp : mst_ok.b_resp;
  assign slv.b_user = wsel ? mst_err.b_user : mst_ok.b_user;
  assign slv.r_id   = rsel ? mst_err.r_id   : mst_ok.r_id;
  assign slv.r_data = rsel ? mst_err.r_data : mst_ok.r_data;
  assign slv.r_resp = rsel ? mst_err.r_resp : mst_ok.r_resp;
  assign slv.r_last = rsel ? mst_err.r_last : mst_ok.r_last;
  assign slv.r_user = rsel ? mst_err.r_user : mst_ok.r_user;

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wsel    <= 1'b0;
      rsel    <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (aw_accept) wsel <= ~aw_hit;
      if (ar_accept) rsel <= ~ar_hit;
    end
  end

  // Write channel routing and next state; everything is quiet while in reset.
  always_comb begin
    w_next           = w_state;
    aw_accept        = 1'b0;
    mst_ok.aw_valid  = 1'b0;
    mst_err.aw_valid = 1'b0;
    slv.aw_ready     = 1'b0;
    mst_ok.w_valid   = 1'b0;
    mst_err.w_valid  = 1'b0;
    slv.w_ready      = 1'b0;
    slv.b_valid      = 1'b0;
    mst_ok.b_ready   = 1'b0;
    mst_err.b_ready  = 1'b0;
    if (!areset) begin
      unique case (w_state)
        W_IDLE: begin
          mst_ok.aw_valid  = slv.aw_valid & aw_hit;
          mst_err.aw_valid = slv.aw_valid & ~aw_hit;
          slv.aw_ready     = aw_dec_ready;
          aw_accept        = slv.aw_valid & aw_dec_ready;
          if (aw_accept) w_next = W_DATA;
        end
        W_DATA: begin
          mst_ok.w_valid  = slv.w_valid & ~wsel;
          mst_err.w_valid = slv.w_valid & wsel;
          slv.w_ready     = w_sel_ready;
          if (slv.w_valid && w_sel_ready && slv.w_last) w_next = W_RESP;
        end
        W_RESP: begin
          slv.b_valid     = b_sel_valid;
          mst_ok.b_ready  = slv.b_ready & ~wsel;
          mst_err.b_ready = slv.b_ready & wsel;
          if (b_sel_valid && slv.b_ready) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  // Read channel routing and next state.
  always_comb begin
    r_next           = r_state;
    ar_accept        = 1'b0;
    mst_ok.ar_valid  = 1'b0;
    mst_err.ar_valid = 1'b0;
    slv.ar_ready     = 1'b0;
    slv.r_valid      = 1'b0;
    mst_ok.r_ready   = 1'b0;
    mst_err.r_ready  = 1'b0;
    if (!areset) begin
      unique case (r_state)
        R_IDLE: begin
          mst_ok.ar_valid  = slv.ar_valid & ar_hit;
          mst_err.ar_valid = slv.ar_valid & ~ar_hit;
          slv.ar_ready     = ar_dec_ready;
          ar_accept        = slv.ar_valid & ar_dec_ready;
          if (ar_accept) r_next = R_BUSY;
        end
        R_BUSY: begin
          slv.r_valid     = r_sel_valid;
          mst_ok.r_ready  = slv.r_ready & ~rsel;
          mst_err.r_ready = slv.r_ready & rsel;
          if (r_sel_valid && slv.r_ready && slv.r_last) r_next = R_IDLE;
        end
      endcase
    end
  end

`ifdef AXI_ADDR_FILTER_LOG_EN
  logic aw_miss, ar_miss;

  assign aw_miss = aw_accept & ~aw_hit;
  assign ar_miss = ar_accept & ~ar_hit;

  // Holds the first miss until cleared; AW beats AR when both miss together.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
    end else if (!err_valid_o && (aw_miss || ar_miss)) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= aw_miss ? slv.aw_addr : slv.ar_addr;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_axi_addr_filter.sv
// Directed bench for axi_addr_filter: upstream driver, two downstream responders,
// and a scoreboard of expected channel traffic.
module tb_axi_addr_filter;

  localparam int CH_AW = 0, CH_W = 1, CH_B = 2, CH_AR = 3, CH_R = 4;

  typedef struct packed {
    logic [1:0]  port;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic areset;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[5][$];

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) slv_bus ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) ok_bus ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) err_bus ();

`ifdef AXI_ADDR_FILTER_LOG_EN
  logic [31:0] err_addr;
  logic        err_valid;
  logic        err_clr;
`endif

  axi_addr_filter dut (
    .aclk    (clk),
    .areset  (areset),
    .slv     (slv_bus),
    .mst_ok  (ok_bus),
    .mst_err (err_bus)
`ifdef AXI_ADDR_FILTER_LOG_EN
    ,
    .err_addr_o  (err_addr),
    .err_valid_o (err_valid),
    .err_clr_i   (err_clr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string ch_name(input int ch);
    case (ch)
      CH_AW:   return "aw";
      CH_W:    return "w";
      CH_B:    return "b";
      CH_AR:   return "ar";
      default: return "r";
    endcase
  endfunction

  task automatic sb_check(input int ch, input exp_t obs);
    exp_t e;
    if (sbq[ch].size() == 0) begin
      chk({ch_name(ch), "_unexpected"}, 64'(sbq[ch].size()), 64'd1);
      return;
    end
    e = sbq[ch].pop_front();
    chk({ch_name(ch), "_beat"}, 64'(obs), 64'(e));
  endtask

  function automatic logic [1:0] port_of(input logic [31:0] a);
    return ((a & 32'hFFF0_0000) == 32'h1FC0_0000) ? 2'd0 : 2'd1;
  endfunction

  function automatic logic [1:0] resp_of(input logic [1:0] p);
    return (p == 2'd0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] wdata(input logic [3:0] id, input int i);
    return 32'hDA7A_0000 | (32'(id) << 8) | 32'(i);
  endfunction

  // ---------------- downstream responders (mst_ok: OKAY, mst_err: DECERR) ----------------
  logic [3:0]  k_bid, k_rid, e_bid, e_rid;
  logic        k_bpend, k_rbusy, e_bpend, e_rbusy;
  logic [31:0] k_raddr, e_raddr;
  logic [7:0]  k_rlen, k_rcnt, e_rlen, e_rcnt;

  assign ok_bus.aw_ready  = 1'b1;
  assign ok_bus.w_ready   = 1'b1;
  assign ok_bus.ar_ready  = 1'b1;
  assign ok_bus.b_valid   = k_bpend;
  assign ok_bus.b_id      = k_bid;
  assign ok_bus.b_resp    = 2'b00;
  assign ok_bus.b_user    = 1'b0;
  assign ok_bus.r_valid   = k_rbusy;
  assign ok_bus.r_id      = k_rid;
  assign ok_bus.r_data    = k_raddr + 32'(k_rcnt);
  assign ok_bus.r_resp    = 2'b00;
  assign ok_bus.r_last    = (k_rcnt == k_rlen);
  assign ok_bus.r_user    = 1'b0;

  assign err_bus.aw_ready = 1'b1;
  assign err_bus.w_ready  = 1'b1;
  assign err_bus.ar_ready = 1'b1;
  assign err_bus.b_valid  = e_bpend;
  assign err_bus.b_id     = e_bid;
  assign err_bus.b_resp   = 2'b11;
  assign err_bus.b_user   = 1'b0;
  assign err_bus.r_valid  = e_rbusy;
  assign err_bus.r_id     = e_rid;
  assign err_bus.r_data   = e_raddr + 32'(e_rcnt);
  assign err_bus.r_resp   = 2'b11;
  assign err_bus.r_last   = (e_rcnt == e_rlen);
  assign err_bus.r_user   = 1'b0;

  always @(posedge clk) begin
    if (areset) begin
      k_bpend <= 1'b0; k_rbusy <= 1'b0; k_rcnt <= '0; k_rlen <= '0;
      k_bid <= '0; k_rid <= '0; k_raddr <= '0;
    end else begin
      if (ok_bus.aw_valid) k_bid <= ok_bus.aw_id;
      if (ok_bus.w_valid && ok_bus.w_last) k_bpend <= 1'b1;
      else if (ok_bus.b_ready) k_bpend <= 1'b0;
      if (ok_bus.ar_valid) begin
        k_rbusy <= 1'b1; k_raddr <= ok_bus.ar_addr; k_rlen <= ok_bus.ar_len;
        k_rcnt <= '0; k_rid <= ok_bus.ar_id;
      end else if (k_rbusy && ok_bus.r_ready) begin
        k_rcnt <= k_rcnt + 8'd1;
        if (k_rcnt == k_rlen) k_rbusy <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (areset) begin
      e_bpend <= 1'b0; e_rbusy <= 1'b0; e_rcnt <= '0; e_rlen <= '0;
      e_bid <= '0; e_rid <= '0; e_raddr <= '0;
    end else begin
      if (err_bus.aw_valid) e_bid <= err_bus.aw_id;
      if (err_bus.w_valid && err_bus.w_last) e_bpend <= 1'b1;
      else if (err_bus.b_ready) e_bpend <= 1'b0;
      if (err_bus.ar_valid) begin
        e_rbusy <= 1'b1; e_raddr <= err_bus.ar_addr; e_rlen <= err_bus.ar_len;
        e_rcnt <= '0; e_rid <= err_bus.ar_id;
      end else if (e_rbusy && err_bus.r_ready) begin
        e_rcnt <= e_rcnt + 8'd1;
        if (e_rcnt == e_rlen) e_rbusy <= 1'b0;
      end
    end
  end

  // ---------------- monitor: handshakes seen mid-cycle, checked against scoreboard ----------------
  always @(negedge clk) begin
    if (!areset) begin
      if (ok_bus.aw_valid || err_bus.aw_valid)
        chk("aw_one_port", 64'(ok_bus.aw_valid & err_bus.aw_valid), 64'd0);
      if (ok_bus.w_valid || err_bus.w_valid)
        chk("w_one_port", 64'(ok_bus.w_valid & err_bus.w_valid), 64'd0);
      if (ok_bus.ar_valid || err_bus.ar_valid)
        chk("ar_one_port", 64'(ok_bus.ar_valid & err_bus.ar_valid), 64'd0);
      if (ok_bus.aw_valid && ok_bus.aw_ready)
        sb_check(CH_AW, '{2'd0, ok_bus.aw_id, ok_bus.aw_len, ok_bus.aw_addr, 2'b00, 1'b0});
      if (err_bus.aw_valid && err_bus.aw_ready)
        sb_check(CH_AW, '{2'd1, err_bus.aw_id, err_bus.aw_len, err_bus.aw_addr, 2'b00, 1'b0});
      if (ok_bus.w_valid && ok_bus.w_ready)
        sb_check(CH_W, '{2'd0, 4'd0, 8'd0, ok_bus.w_data, 2'b00, ok_bus.w_last});
      if (err_bus.w_valid && err_bus.w_ready)
        sb_check(CH_W, '{2'd1, 4'd0, 8'd0, err_bus.w_data, 2'b00, err_bus.w_last});
      if (ok_bus.ar_valid && ok_bus.ar_ready)
        sb_check(CH_AR, '{2'd0, ok_bus.ar_id, ok_bus.ar_len, ok_bus.ar_addr, 2'b00, 1'b0});
      if (err_bus.ar_valid && err_bus.ar_ready)
        sb_check(CH_AR, '{2'd1, err_bus.ar_id, err_bus.ar_len, err_bus.ar_addr, 2'b00, 1'b0});
      if (slv_bus.b_valid && slv_bus.b_ready)
        sb_check(CH_B, '{2'd0, slv_bus.b_id, 8'd0, 32'd0, slv_bus.b_resp, 1'b0});
      if (slv_bus.r_valid && slv_bus.r_ready)
        sb_check(CH_R, '{2'd0, slv_bus.r_id, 8'd0, slv_bus.r_data, slv_bus.r_resp, slv_bus.r_last});
    end
  end

  // ---------------- upstream driver tasks ----------------
  task automatic exp_write(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    logic [1:0] p = port_of(a);
    sbq[CH_AW].push_back('{p, id, len, a, 2'b00, 1'b0});
    for (int i = 0; i <= int'(len); i++)
      sbq[CH_W].push_back('{p, 4'd0, 8'd0, wdata(id, i), 2'b00, (i == int'(len))});
    sbq[CH_B].push_back('{2'd0, id, 8'd0, 32'd0, resp_of(p), 1'b0});
  endtask

  task automatic exp_read(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    logic [1:0] p = port_of(a);
    sbq[CH_AR].push_back('{p, id, len, a, 2'b00, 1'b0});
    for (int i = 0; i <= int'(len); i++)
      sbq[CH_R].push_back('{2'd0, id, 8'd0, a + 32'(i), resp_of(p), (i == int'(len))});
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    logic hs = 1'b0;
    slv_bus.aw_addr = a; slv_bus.aw_len = len; slv_bus.aw_id = id; slv_bus.aw_valid = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = slv_bus.aw_ready;
      @(posedge clk); #1;
    end
    slv_bus.aw_valid = 1'b0;
    chk("aw_accept", 64'(hs), 64'd1);
  endtask

  task automatic w_send(input logic [31:0] d, input logic last);
    logic hs = 1'b0;
    slv_bus.w_data = d; slv_bus.w_last = last; slv_bus.w_valid = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = slv_bus.w_ready;
      @(posedge clk); #1;
    end
    slv_bus.w_valid = 1'b0;
    chk("w_accept", 64'(hs), 64'd1);
  endtask

  task automatic b_wait();
    logic hs = 1'b0;
    slv_bus.b_ready = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = slv_bus.b_valid;
      @(posedge clk); #1;
    end
    slv_bus.b_ready = 1'b0;
    chk("b_seen", 64'(hs), 64'd1);
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    logic hs = 1'b0;
    slv_bus.ar_addr = a; slv_bus.ar_len = len; slv_bus.ar_id = id; slv_bus.ar_valid = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = slv_bus.ar_ready;
      @(posedge clk); #1;
    end
    slv_bus.ar_valid = 1'b0;
    chk("ar_accept", 64'(hs), 64'd1);
  endtask

  task automatic r_recv(input int n);
    int cnt = 0;
    slv_bus.r_ready = 1'b1;
    for (int i = 0; i < 200 && cnt < n; i++) begin
      @(negedge clk); if (slv_bus.r_valid) cnt++;
      @(posedge clk); #1;
    end
    slv_bus.r_ready = 1'b0;
    chk("r_beat_count", 64'(cnt), 64'(n));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    exp_write(a, len, id);
    aw_send(a, len, id);
    for (int i = 0; i <= int'(len); i++) w_send(wdata(id, i), (i == int'(len)));
    b_wait();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    exp_read(a, len, id);
    ar_send(a, len, id);
    r_recv(int'(len) + 1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_fwd_valid"}, 64'({ok_bus.aw_valid, ok_bus.w_valid, ok_bus.ar_valid,
        err_bus.aw_valid, err_bus.w_valid, err_bus.ar_valid}), 64'd0);
    chk({tag, "_resp_valid"}, 64'({slv_bus.b_valid, slv_bus.r_valid}), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    areset = 1'b1;
    slv_bus.aw_id = '0; slv_bus.aw_addr = '0; slv_bus.aw_len = '0; slv_bus.aw_size = 3'd2;
    slv_bus.aw_burst = 2'b01; slv_bus.aw_lock = 1'b0; slv_bus.aw_cache = '0; slv_bus.aw_prot = '0;
    slv_bus.aw_qos = '0; slv_bus.aw_region = '0; slv_bus.aw_user = '0; slv_bus.aw_valid = 1'b0;
    slv_bus.w_data = '0; slv_bus.w_strb = 4'hF; slv_bus.w_last = 1'b0; slv_bus.w_user = '0;
    slv_bus.w_valid = 1'b0; slv_bus.b_ready = 1'b0;
    slv_bus.ar_id = '0; slv_bus.ar_addr = '0; slv_bus.ar_len = '0; slv_bus.ar_size = 3'd2;
    slv_bus.ar_burst = 2'b01; slv_bus.ar_lock = 1'b0; slv_bus.ar_cache = '0; slv_bus.ar_prot = '0;
    slv_bus.ar_qos = '0; slv_bus.ar_region = '0; slv_bus.ar_user = '0; slv_bus.ar_valid = 1'b0;
    slv_bus.r_ready = 1'b0;
`ifdef AXI_ADDR_FILTER_LOG_EN
    err_clr = 1'b0;
`endif

    // Requests offered during reset must not leak downstream.
    repeat (2) @(posedge clk);
    #1;
    slv_bus.aw_addr = 32'h1FC0_0000; slv_bus.aw_valid = 1'b1;
    slv_bus.ar_addr = 32'h8000_0000; slv_bus.ar_valid = 1'b1;
    @(negedge clk);
    check_quiet("reset");
    chk("reset_slv_ready", 64'({slv_bus.aw_ready, slv_bus.ar_ready, slv_bus.w_ready}), 64'd0);
    @(posedge clk); #1;
    slv_bus.aw_valid = 1'b0; slv_bus.ar_valid = 1'b0;
    areset = 1'b0;
    @(negedge clk);
    check_quiet("idle");
`ifdef AXI_ADDR_FILTER_LOG_EN
    chk("log_reset_valid", 64'(err_valid), 64'd0);
    chk("log_reset_addr", 64'(err_addr), 64'd0);
`endif
    @(posedge clk); #1;

    // Single-beat hit write, then multi-beat miss read.
    do_write(32'h1FC0_0010, 8'd0, 4'd3);
    do_read(32'h8000_0000, 8'd3, 4'd1);
    // Miss write, hit read, and back-to-back writes.
    do_write(32'h4000_0000, 8'd2, 4'd9);
    do_read(32'h1FC0_0040, 8'd1, 4'd2);
    do_write(32'h1FCF_FFF0, 8'd1, 4'd10);

    // Concurrent hit write and miss read.
    fork
      do_write(32'h1FC0_0000, 8'd3, 4'd1);
      do_read(32'h0000_1000, 8'd2, 4'd4);
    join

    // W beat presented ahead of its AW is stalled.
    exp_write(32'h1FC0_0020, 8'd1, 4'd5);
    slv_bus.w_data = wdata(4'd5, 0); slv_bus.w_last = 1'b0; slv_bus.w_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("early_w_ready", 64'(slv_bus.w_ready), 64'd0);
      chk("early_w_fwd", 64'({ok_bus.w_valid, err_bus.w_valid}), 64'd0);
      @(posedge clk); #1;
    end
    aw_send(32'h1FC0_0020, 8'd1, 4'd5);
    w_send(wdata(4'd5, 0), 1'b0);
    w_send(wdata(4'd5, 1), 1'b1);
    b_wait();

    // Reset in the middle of an 8-beat burst.
    exp_write(32'h1FC0_0100, 8'd7, 4'd6);
    aw_send(32'h1FC0_0100, 8'd7, 4'd6);
    w_send(wdata(4'd6, 0), 1'b0);
    w_send(wdata(4'd6, 1), 1'b0);
    areset = 1'b1;
    slv_bus.w_data = wdata(4'd6, 2); slv_bus.w_valid = 1'b1;
    @(negedge clk);
    check_quiet("midreset");
    @(posedge clk); #1;
    areset = 1'b0;
    for (int c = 0; c < 5; c++) sbq[c].delete();
    @(negedge clk);
    check_quiet("post_reset");
    chk("post_reset_w_ready", 64'(slv_bus.w_ready), 64'd0);
    @(posedge clk); #1;
    slv_bus.w_valid = 1'b0;
    do_write(32'h1FC0_0200, 8'd1, 4'd7);
    do_read(32'h1FC0_0300, 8'd0, 4'd8);

`ifdef AXI_ADDR_FILTER_LOG_EN
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("log_cleared", 64'(err_valid), 64'd0);
    @(posedge clk); #1;
    do_write(32'h9000_0004, 8'd0, 4'd1);
    @(negedge clk);
    chk("log_first_valid", 64'(err_valid), 64'd1);
    chk("log_first_addr", 64'(err_addr), 64'h9000_0004);
    @(posedge clk); #1;
    do_read(32'hA000_0000, 8'd0, 4'd2);
    @(negedge clk);
    chk("log_hold_addr", 64'(err_addr), 64'h9000_0004);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("log_clear_valid", 64'(err_valid), 64'd0);
    @(posedge clk); #1;
    do_write(32'hA000_0000, 8'd0, 4'd3);
    @(negedge clk);
    chk("log_second_valid", 64'(err_valid), 64'd1);
    chk("log_second_addr", 64'(err_addr), 64'hA000_0000);
`endif

    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) chk({ch_name(c), "_drained"}, 64'(sbq[c].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_addr_filter.md
AXI_ADDR_FILTER -- requirements
Module: axi_addr_filter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1FC0_0000: base address of the mapped window.
REQ-002 SHALL have parameter ADDR_MASK, default 32'hFFF0_0000: a request hits when (addr & ADDR_MASK) == BASE_ADDR.
REQ-003 SHALL have port aclk, input, 1: the single clock.
REQ-004 SHALL have port areset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port slv, AXI_BUS.Slave, 32b addr / 32b data / 4b ID / 1b user: upstream request port.
REQ-006 SHALL have port mst_ok, AXI_BUS.Master, same widths: mapped downstream target.
REQ-007 SHALL have port mst_err, AXI_BUS.Master, same widths: feeds the error slave (DECERR responder).
REQ-008 SHALL have port err_addr_o, output, 32: first faulting address (present only with the logging feature).
REQ-009 SHALL have port err_valid_o, output, 1: err_addr_o holds a captured address (logging feature only).
REQ-010 SHALL have port err_clr_i, input, 1: clears the capture (logging feature only).

Function
REQ-011 SHALL decode AW/AR addresses combinationally: hit routes to mst_ok; miss routes to mst_err.
REQ-012 SHALL forward every channel field unmodified to and from the selected port, with 0-cycle combinational latency.
REQ-013 SHALL hold VALID low on the non-selected master port and hold READY low on slv for any channel not currently routed.
REQ-014 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
- W_IDLE: AW is routed by decode; wready=0.
- On an AW handshake, SHALL latch the selected port (wsel) and go to W_DATA.
REQ-015 In W_DATA, W SHALL be routed to wsel; a handshake with WLAST=1 SHALL go to W_RESP. awready SHALL be 0 in W_DATA and W_RESP.
REQ-016 In W_RESP, B SHALL be routed from wsel; a B handshake SHALL go to W_IDLE.
REQ-017 Read FSM SHALL have states R_IDLE, R_BUSY.
- R_IDLE: AR is routed by decode; an AR handshake latches rsel and goes to R_BUSY.
- R_BUSY: R is routed from rsel; arready=0; an R handshake with RLAST=1 goes to R_IDLE.
REQ-018 Read and write FSMs SHALL be independent; a concurrent read and write SHALL each proceed, to the same or different ports.
REQ-019 SHALL allow at most one outstanding transaction per direction; consecutive transactions in one direction SHALL have a minimum one-cycle gap between the last B/R handshake and the next AW/AR acceptance.
REQ-020 W beats presented in W_IDLE SHALL be stalled (wready=0) until the AW is accepted.
REQ-021 B/R valids arriving from a non-selected port SHALL be ignored (their ready held 0).

Reset
REQ-022 On areset=1 at a rising aclk edge, both FSMs SHALL return to IDLE and wsel/rsel SHALL clear to mst_ok.
REQ-023 While in reset or IDLE, all forwarded VALID outputs SHALL be 0, except AW/AR valid to the decoded port in IDLE; during reset those SHALL be 0 as well.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no further beats forwarded; downstream ports are reset in the same domain.
REQ-025 err_valid_o SHALL reset to 0 and err_addr_o SHALL reset to 32'h0.

Configuration
REQ-026 Macro AXI_ADDR_FILTER_LOG_EN defined: on the first miss AW or AR handshake while err_valid_o=0, SHALL capture the address into err_addr_o and set err_valid_o the next cycle.
- err_clr_i=1 SHALL clear err_valid_o the next cycle.
- If err_clr_i and a capture occur in the same cycle, the capture SHALL win.
- If AW and AR miss in the same cycle, the AW address SHALL win.
REQ-027 Macro AXI_ADDR_FILTER_LOG_EN undefined: ports err_addr_o, err_valid_o and err_clr_i and their logic SHALL be absent.

Verification
REQ-028 Write to 0x1FC0_0010, AWLEN=0, ID=3 -> AW/W appear on mst_ok only; BRESP=OKAY, BID=3 returned on slv.
REQ-029 Read 0x8000_0000, ARLEN=3 -> AR on mst_err; 4 R beats with RRESP=DECERR forwarded, RLAST on beat 4; then R_IDLE.
REQ-030 Concurrent write to 0x1FC0_0000 (hit) and read from 0x0000_1000 (miss) -> both complete on their respective ports with no cross-routing.
REQ-031 W presented 2 cycles before AW -> wready=0 until the AW handshake; all beats arrive in order on the selected port.
REQ-032 areset asserted after beat 2 of an AWLEN=7 burst -> next cycle both FSMs are IDLE and all valids are 0; a following fresh write completes normally.
REQ-033 With AXI_ADDR_FILTER_LOG_EN: miss at 0x9000_0004, then miss at 0xA000_0000 -> err_addr_o=0x9000_0004; after err_clr_i, a miss at 0xA000_0000 captures 0xA000_0000.
